// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and the control
// vectors the hazard controller drives into the pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RELEASE = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
  };

  // Whole pipeline holds; MEM/WB writeback suppressed so the stalled access
  // is not retired twice.
  localparam hz_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1
  };

  localparam hz_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
  };

  localparam hz_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
  };

  function automatic logic load_use_hazard(
    input logic       memread,
    input logic [4:0] ex_rt,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return memread && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the pipeline (master side)
// and the stage enables/flushes returned by the controller (slave side).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_ex_rt;
  logic             id_ex_memread;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_ex_rt, id_ex_memread, branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush,
           halted, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_ex_rt, id_ex_memread, branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush,
           halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout halt, branch
// flush and load-use stall, plus a saturating count of frozen-PC cycles.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("pipe_hazard_ctrl: MAX_WAIT must be at least 1");
  end

  hz_state_e         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halted_q;
  hz_ctrl_t          ctrl;
  logic              mem_stall;
  logic              lu_hazard;

  assign mem_stall = hz.dmem_req && !hz.dmem_ready;
  assign lu_hazard = load_use_hazard(hz.id_ex_memread, hz.id_ex_rt, hz.id_rs, hz.id_rt);

  // Outputs are Mealy: the freeze must take effect in the cycle the memory
  // reports not-ready, not one cycle later.
  always_comb begin
    ctrl = CTRL_RELEASE;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_stall)            ctrl = CTRL_FREEZE;
          else if (hz.branch_taken) ctrl = CTRL_BRANCH;
          else if (lu_hazard)       ctrl = CTRL_LOAD_USE;
        end
        MEM_WAIT: begin
          if (!hz.dmem_ready)       ctrl = CTRL_FREEZE;
        end
        HALT:                       ctrl = CTRL_FREEZE;
        default:                    ctrl = CTRL_RELEASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (!ctrl.pc_en),
    .count (hz.stall_cnt)
  );

  assign hz.pc_en        = ctrl.pc_en;
  assign hz.if_id_en     = ctrl.if_id_en;
  assign hz.if_id_flush  = ctrl.if_id_flush;
  assign hz.id_ex_flush  = ctrl.id_ex_flush;
  assign hz.ex_mem_en    = ctrl.ex_mem_en;
  assign hz.mem_wb_flush = ctrl.mem_wb_flush;
  assign hz.halted       = halted_q && !rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MAX_WAIT=4, CNT_W=3): vector
// table for single-cycle RUN decisions plus multi-cycle memory/halt sequences.
module tb_pipe_hazard_ctrl;

  localparam int MAXW  = 4;
  localparam int CW    = 3;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [5:0] E_NORM = 6'b110010;
  localparam logic [5:0] E_FRZ  = 6'b000001;
  localparam logic [5:0] E_BR   = 6'b111110;
  localparam logic [5:0] E_LU   = 6'b000110;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] ex_rt;
    logic       memread;
    logic       branch;
    logic       req;
    logic       ready;
  } stim_t;

  typedef struct packed {
    logic [5:0]    ctrl;
    logic          halted;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    stim_t      s;
    logic [5:0] ctrl;
    logic       halted;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [CW-1:0] model_cnt = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

  pipe_hazard_ctrl #(
    .MAX_WAIT (MAXW),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.slave)
  );

  function automatic stim_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] ex_rt, input logic memread,
                               input logic branch, input logic req, input logic ready);
    stim_t s;
    s.rst = r; s.rs = rs; s.rt = rt; s.ex_rt = ex_rt;
    s.memread = memread; s.branch = branch; s.req = req; s.ready = ready;
    return s;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    logic [5:0] got;
    e = sb.pop_front();
    got = {hz_if.pc_en, hz_if.if_id_en, hz_if.if_id_flush,
           hz_if.id_ex_flush, hz_if.ex_mem_en, hz_if.mem_wb_flush};
    checks++;
    if (got !== e.ctrl) begin
      fails++;
      $display("FAIL %s ctrl: got %b expected %b", name, got, e.ctrl);
    end
    checks++;
    if (hz_if.halted !== e.halted) begin
      fails++;
      $display("FAIL %s halted: got %b expected %b", name, hz_if.halted, e.halted);
    end
    checks++;
    if (hz_if.stall_cnt !== e.cnt) begin
      fails++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", name, hz_if.stall_cnt, e.cnt);
    end
  endtask

  task automatic step(input stim_t s, input logic [5:0] ec, input logic eh, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    hz_if.id_rs         = s.rs;
    hz_if.id_rt         = s.rt;
    hz_if.id_ex_rt      = s.ex_rt;
    hz_if.id_ex_memread = s.memread;
    hz_if.branch_taken  = s.branch;
    hz_if.dmem_req      = s.req;
    hz_if.dmem_ready    = s.ready;
    e.ctrl   = ec;
    e.halted = eh;
    e.cnt    = model_cnt;
    sb.push_back(e);
    @(negedge clk);
    check_out(name);
    if (s.rst)                            model_cnt = '0;
    else if (!ec[5] && model_cnt != CNT_MAX) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic idle(input logic [5:0] ec, input logic eh, input string name);
    step(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), ec, eh, name);
  endtask

  task automatic do_reset(input string name);
    step(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_NORM, 1'b0, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    stim_t s_freeze;
    stim_t s_ready;

    tbl[0] = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_NORM, 1'b0};
    tbl[1] = '{mk(1'b0, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0), E_LU,   1'b0};
    tbl[2] = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_NORM, 1'b0};
    tbl[3] = '{mk(1'b0, 5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0), E_BR,   1'b0};
    tbl[4] = '{mk(1'b0, 5'd3, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0), E_LU,   1'b0};
    tbl[5] = '{mk(1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0), E_NORM, 1'b0};
    tbl[6] = '{mk(1'b0, 5'd9, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0), E_NORM, 1'b0};
    tbl[7] = '{mk(1'b0, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1), E_LU,   1'b0};
    tbl[8] = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), E_BR,   1'b0};

    s_freeze = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    s_ready  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    hz_if.id_rs = '0; hz_if.id_rt = '0; hz_if.id_ex_rt = '0;
    hz_if.id_ex_memread = 1'b0; hz_if.branch_taken = 1'b0;
    hz_if.dmem_req = 1'b0; hz_if.dmem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_cnt = '0;

    do_reset("reset");
    for (int i = 0; i < $size(tbl); i++)
      step(tbl[i].s, tbl[i].ctrl, tbl[i].halted, $sformatf("table[%0d]", i));
    idle(E_NORM, 1'b0, "after_table");

    // memory wait of three cycles then release
    do_reset("reset_mw");
    for (int i = 0; i < 3; i++) step(s_freeze, E_FRZ, 1'b0, $sformatf("mw_freeze%0d", i));
    step(s_ready, E_NORM, 1'b0, "mw_release");
    idle(E_NORM, 1'b0, "mw_after");

    // timeout into HALT, which ignores ready until reset
    do_reset("reset_halt");
    for (int i = 0; i < 5; i++) step(s_freeze, E_FRZ, 1'b0, $sformatf("to_freeze%0d", i));
    step(s_ready, E_FRZ, 1'b1, "halt_ready");
    idle(E_FRZ, 1'b1, "halt_idle");
    step(mk(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0), E_NORM, 1'b0, "halt_rst");
    idle(E_NORM, 1'b0, "post_halt");

    // reset in the middle of a memory wait, then a full timeout again
    for (int i = 0; i < 2; i++) step(s_freeze, E_FRZ, 1'b0, $sformatf("mid_freeze%0d", i));
    do_reset("mid_rst");
    for (int i = 0; i < 5; i++) step(s_freeze, E_FRZ, 1'b0, $sformatf("re_freeze%0d", i));
    step(s_freeze, E_FRZ, 1'b1, "re_halt");

    // continuous 10-cycle freeze saturates the 3-bit counter
    do_reset("reset_sat");
    for (int i = 0; i < 10; i++)
      step(s_freeze, E_FRZ, (i >= 5), $sformatf("sat%0d", i));
    idle(E_FRZ, 1'b1, "sat_hold");

    checks++;
    if (hz_if.stall_cnt !== CNT_MAX) begin
      fails++;
      $display("FAIL sat_final stall_cnt: got %0d expected %0d", hz_if.stall_cnt, CNT_MAX);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
